dp_job_arbiter: RTL and testbench
=================================

Name: dp_job_arbiter

Overview:
- Shares one datapath/controller pair between two requesters (channel 0, channel 1).
- Takes a job (x operand + mode) from a requester, round-robin when both ask.
- Drives the controller's on/start inputs and holds x stable for the whole run.
- Captures y/s/b when the controller drops active, returns them with a done pulse, and flags controller timeouts.

Parameters:
- START_TMO, 8: max cycles from start pulse to active rising.
- RUN_TMO, 64: max cycles with active high.
- TMO_W, 7: timeout counter width; must be at least clog2(max(START_TMO,RUN_TMO)+1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  2  per-channel job request, held until that channel's done
- x0  in  8  channel 0 operand
- x1  in  8  channel 1 operand
- mode0  in  2  channel 0 mode, driven to controller on
- mode1  in  2  channel 1 mode, driven to controller on
- gnt  out  2  one-hot grant, high from accept to done
- done  out  2  one-cycle per-channel completion pulse
- err  out  1  valid with done: job aborted on timeout
- res_y  out  8  captured y
- res_s  out  3  captured s
- res_b  out  1  captured b
- cp_on  out  2  to controller on
- cp_start  out  1  to controller start
- dp_x  out  8  to datapath x
- cp_active  in  1  from controller active
- dp_y  in  8  from datapath y
- dp_s  in  3  from datapath s
- dp_b  in  1  from datapath b

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; gnt=0, done=0, err=0, res_*=0, cp_on=0, cp_start=0, dp_x=0; last-served pointer=1, so channel 0 wins the first tie.
- IDLE:
  - If any req bit is set, pick a channel: a lone requester wins; if both request, the one not last served wins.
  - Latch that channel's x and mode into dp_x/cp_on.
  - Set gnt one-hot, update the pointer, go to LAUNCH.
- LAUNCH: cp_start=1 for exactly one cycle; clear timeout counter; go to WAIT_ACT.
- WAIT_ACT:
  - cp_active=1: go to RUN and clear the counter.
  - Otherwise increment the counter.
  - Counter reaching START_TMO: go to FINISH with err=1.
- RUN:
  - cp_active=0: capture dp_y/dp_s/dp_b into res_* on that same edge, go to FINISH with err=0.
  - Otherwise increment the counter.
  - Counter reaching RUN_TMO: go to FINISH with err=1; res_* keep their previous values.
- FINISH:
  - done[granted]=1 for one cycle; err is valid in this cycle only.
  - Set cp_on=0 and gnt=0 on exit; go to IDLE.
- Interface stability:
  - dp_x and cp_on are constant from LAUNCH through RUN.
  - res_* hold their value until the next successful capture.
- Requester changes mid-job:
  - Changes to req, x or mode of any channel are ignored while busy.
  - Dropping req mid-job does not abort the job; done still pulses.
- Back-to-back jobs:
  - Minimum job latency, req to done: IDLE, LAUNCH, WAIT_ACT (≥1), RUN (≥1), FINISH = 5 cycles.
  - A held req is re-arbitrated in the IDLE cycle after FINISH.
  - With both channels continuously requesting, service alternates 0,1,0,1.
- Activity edge cases:
  - cp_active already high in LAUNCH: ignored; only WAIT_ACT samples it.
  - cp_active pulse of one cycle: WAIT_ACT→RUN, then RUN sees 0 and captures next cycle.
- Reset asserted mid-job: everything returns to reset values immediately; no done is issued for the aborted job.
- Timeout counter saturates and never wraps; compare uses ≥.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=0, LAUNCH=1, WAIT_ACT=2, RUN=3, FINISH=4, 3-bit.
  - Channel count constant (2).
  - Default timeout values.
- One natural sub-module: rr_arb2, a 2-input round-robin picker (req[1:0] and last pointer in, one-hot gnt out).
  - Purely combinational.
  - Pointer register stays in the parent so reset behaviour is centralised.

Test Plan:
- Single job:
  - Stimulus: req=01, x0=8'h2A, mode0=2'b10; controller model raises active 2 cycles after start, drops it after 5, with dp_y=8'h55, dp_s=3'd4, dp_b=1.
  - Response: cp_start one pulse; dp_x=8'h2A and cp_on=2'b10 throughout; done=01 with err=0; res_y=8'h55, res_s=4, res_b=1.
- Contention:
  - Stimulus: req=11 held for 4 jobs from reset.
  - Response: gnt sequence 01,10,01,10; done pulses in the same order; each dp_x matches the granted channel.
- Start timeout:
  - Stimulus: cp_active stuck 0.
  - Response: done pulses START_TMO+3 cycles after accept with err=1; res_* unchanged; next req is served normally.
- Run timeout:
  - Stimulus: cp_active stuck 1 after start.
  - Response: err=1 with done after RUN_TMO cycles in RUN; cp_on returns to 0.
- Mid-job disturbance:
  - Stimulus: x0 changed to 8'hFF and req0 dropped during RUN.
  - Response: dp_x stays at the original value; done0 still pulses once.
- Reset mid-job:
  - Stimulus: rst=0 for 1 cycle during RUN.
  - Response: all outputs are 0 asynchronously, with no done; after release, req=11 grants channel 0 first.

Source files
------------

// File: rtl/dp_job_arbiter_pkg.sv
// Shared types and constants for the two-channel datapath job arbiter.
package dp_job_arbiter_pkg;

   localparam int unsigned NUM_CH        = 2;
   localparam int unsigned DEF_START_TMO = 8;
   localparam int unsigned DEF_RUN_TMO   = 64;
   localparam int unsigned DEF_TMO_W     = 7;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StLaunch  = 3'd1,
      StWaitAct = 3'd2,
      StRun     = 3'd3,
      StFinish  = 3'd4
   } state_e;

endpackage

// File: rtl/dp_job_arbiter_rr_arb2.sv
// Two-input round-robin picker; the last-served pointer lives in the parent.
module rr_arb2
   import dp_job_arbiter_pkg::*;
(
   input  logic [NUM_CH-1:0] i_req,
   input  logic              i_last,
   output logic [NUM_CH-1:0] o_gnt
);

   always_comb begin
      o_gnt = '0;
      unique case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         // On a tie the channel not served last wins.
         2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
         default: o_gnt = '0;
      endcase
   end

endmodule

// File: rtl/dp_job_arbiter.sv
// Shares one datapath/controller pair between two requesters, launching jobs,
// watching the controller for timeouts and returning captured results.
module dp_job_arbiter
   import dp_job_arbiter_pkg::*;
#(
   parameter int unsigned START_TMO = DEF_START_TMO,
   parameter int unsigned RUN_TMO   = DEF_RUN_TMO,
   parameter int unsigned TMO_W     = DEF_TMO_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NUM_CH-1:0] i_req,
   input  logic [7:0]        i_x0,
   input  logic [7:0]        i_x1,
   input  logic [1:0]        i_mode0,
   input  logic [1:0]        i_mode1,
   output logic [NUM_CH-1:0] o_gnt,
   output logic [NUM_CH-1:0] o_done,
   output logic              o_err,
   output logic [7:0]        o_res_y,
   output logic [2:0]        o_res_s,
   output logic              o_res_b,
   output logic [1:0]        o_cp_on,
   output logic              o_cp_start,
   output logic [7:0]        o_dp_x,
   input  logic              i_cp_active,
   input  logic [7:0]        i_dp_y,
   input  logic [2:0]        i_dp_s,
   input  logic              i_dp_b
);

   state_e              r_state, w_state_d;
   logic [TMO_W-1:0]    r_cnt, w_cnt_d, w_cnt_inc;
   logic                r_err, w_err_d;
   logic                r_last;
   logic [NUM_CH-1:0]   r_gnt;
   logic [7:0]          r_dp_x;
   logic [1:0]          r_cp_on;
   logic [7:0]          r_res_y;
   logic [2:0]          r_res_s;
   logic                r_res_b;
   logic [NUM_CH-1:0]   w_pick;
   logic                w_accept;
   logic                w_capture;

   rr_arb2 u_rr_arb2 (
      .i_req  (i_req),
      .i_last (r_last),
      .o_gnt  (w_pick)
   );

   // Saturating increment so a stuck controller can never wrap the counter.
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_err   <= w_err_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_err_d   = r_err;
      w_accept  = 1'b0;
      w_capture = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (|i_req) begin
               w_accept  = 1'b1;
               w_state_d = StLaunch;
            end
         end
         StLaunch: begin
            w_cnt_d   = '0;
            w_err_d   = 1'b0;
            w_state_d = StWaitAct;
         end
         StWaitAct: begin
            if (i_cp_active) begin
               w_cnt_d   = '0;
               w_state_d = StRun;
            end else if (r_cnt >= TMO_W'(START_TMO)) begin
               w_err_d   = 1'b1;
               w_state_d = StFinish;
            end else begin
               w_cnt_d = w_cnt_inc;
            end
         end
         StRun: begin
            if (!i_cp_active) begin
               w_capture = 1'b1;
               w_err_d   = 1'b0;
               w_state_d = StFinish;
            end else if (r_cnt >= TMO_W'(RUN_TMO)) begin
               w_err_d   = 1'b1;
               w_state_d = StFinish;
            end else begin
               w_cnt_d = w_cnt_inc;
            end
         end
         StFinish: w_state_d = StIdle;
         default:  w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last  <= 1'b1;
         r_gnt   <= '0;
         r_dp_x  <= '0;
         r_cp_on <= '0;
         r_res_y <= '0;
         r_res_s <= '0;
         r_res_b <= 1'b0;
      end else begin
         if (w_accept) begin
            r_gnt   <= w_pick;
            r_last  <= w_pick[1];
            r_dp_x  <= w_pick[1] ? i_x1 : i_x0;
            r_cp_on <= w_pick[1] ? i_mode1 : i_mode0;
         end
         if (w_capture) begin
            r_res_y <= i_dp_y;
            r_res_s <= i_dp_s;
            r_res_b <= i_dp_b;
         end
         if (r_state == StFinish) begin
            r_gnt   <= '0;
            r_cp_on <= '0;
         end
      end
   end

   always_comb begin
      o_gnt      = r_gnt;
      o_done     = (r_state == StFinish) ? r_gnt : '0;
      o_err      = (r_state == StFinish) & r_err;
      o_cp_start = (r_state == StLaunch);
      o_cp_on    = r_cp_on;
      o_dp_x     = r_dp_x;
      o_res_y    = r_res_y;
      o_res_s    = r_res_s;
      o_res_b    = r_res_b;
   end

endmodule

// File: tb/tb_dp_job_arbiter.sv
// Directed self-checking bench for dp_job_arbiter with a scripted controller.
module tb_dp_job_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = '0;
   logic [7:0] x0 = '0, x1 = '0;
   logic [1:0] mode0 = '0, mode1 = '0;
   logic [1:0] gnt, done;
   logic       err;
   logic [7:0] res_y;
   logic [2:0] res_s;
   logic       res_b;
   logic [1:0] cp_on;
   logic       cp_start;
   logic [7:0] dp_x;
   logic       cp_active = 1'b0;
   logic [7:0] dp_y = '0;
   logic [2:0] dp_s = '0;
   logic       dp_b = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   dp_job_arbiter dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req       (req),
      .i_x0        (x0),
      .i_x1        (x1),
      .i_mode0     (mode0),
      .i_mode1     (mode1),
      .o_gnt       (gnt),
      .o_done      (done),
      .o_err       (err),
      .o_res_y     (res_y),
      .o_res_s     (res_s),
      .o_res_b     (res_b),
      .o_cp_on     (cp_on),
      .o_cp_start  (cp_start),
      .o_dp_x      (dp_x),
      .i_cp_active (cp_active),
      .i_dp_y      (dp_y),
      .i_dp_s      (dp_s),
      .i_dp_b      (dp_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after done.
   // Controller raises active act_on cycles after start, drops it at act_off.
   task automatic run_job(input logic [1:0] rq, input int act_on, input int act_off,
                          input logic [7:0] y, input logic [2:0] s, input logic b,
                          input int dist_at,
                          output logic [1:0] g, output logic [1:0] dn, output logic e,
                          output int lat, output int starts, output int unstable,
                          output logic [7:0] x_seen, output logic [1:0] on_seen,
                          output logic [1:0] dn_after);
      int t_start;
      t_start = -1;
      req = rq; dp_y = y; dp_s = s; dp_b = b;
      g = '0; dn = '0; e = 1'b0; lat = 0; starts = 0; unstable = 0;
      x_seen = '0; on_seen = '0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (cp_start) begin
            starts++;
            t_start = c;
         end
         if (c == 1) begin
            g = gnt; x_seen = dp_x; on_seen = cp_on;
         end else if (gnt != '0 && (dp_x != x_seen || cp_on != on_seen)) begin
            unstable++;
         end
         if (done != '0) begin
            dn = done; e = err; lat = c;
            break;
         end
         if (c == dist_at) begin
            x0 = 8'hFF;
            req = 2'b00;
         end
         if (t_start >= 0)
            cp_active = ((c - t_start) >= act_on) && ((c - t_start) < act_off);
      end
      cp_active = 1'b0;
      @(negedge clk);
      dn_after = done;
   endtask

   logic [1:0] g, dn, dn_after, on_seen;
   logic       e;
   int         lat, starts, unstable;
   logic [7:0] x_seen;

   initial begin
      #1;
      check_eq("reset_outputs", {gnt, done, err, res_y, res_s, res_b, cp_on, cp_start, dp_x}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single job on channel 0.
      x0 = 8'h2A; mode0 = 2'b10;
      run_job(2'b01, 2, 7, 8'h55, 3'd4, 1'b1, 0,
              g, dn, e, lat, starts, unstable, x_seen, on_seen, dn_after);
      check_eq("single_gnt", g, 2'b01);
      check_eq("single_dpx", x_seen, 8'h2A);
      check_eq("single_cpon", on_seen, 2'b10);
      check_eq("single_starts", starts, 1);
      check_eq("single_stable", unstable, 0);
      check_eq("single_done", dn, 2'b01);
      check_eq("single_err", e, 0);
      check_eq("single_lat", lat, 9);
      check_eq("single_res", {res_y, res_s, res_b}, {8'h55, 3'd4, 1'b1});
      check_eq("single_pulse", dn_after, 2'b00);

      // Contention from reset: both held, service must alternate 0,1,0,1.
      req = 2'b00;
      reset_pulse();
      x0 = 8'h11; x1 = 8'h22; mode0 = 2'b01; mode1 = 2'b10;
      for (int k = 0; k < 4; k++) begin
         run_job(2'b11, 1, 2, 8'h10 + 8'(k), 3'(k), k[0], 0,
                 g, dn, e, lat, starts, unstable, x_seen, on_seen, dn_after);
         check_eq($sformatf("cont%0d_gnt", k), g, k[0] ? 2'b10 : 2'b01);
         check_eq($sformatf("cont%0d_done", k), dn, k[0] ? 2'b10 : 2'b01);
         check_eq($sformatf("cont%0d_dpx", k), x_seen, k[0] ? 8'h22 : 8'h11);
         check_eq($sformatf("cont%0d_cpon", k), on_seen, k[0] ? 2'b10 : 2'b01);
         check_eq($sformatf("cont%0d_lat", k), lat, 4);
         check_eq($sformatf("cont%0d_resy", k), res_y, 8'h10 + 8'(k));
      end

      // Start timeout on channel 1: active never rises.
      req = 2'b00;
      @(negedge clk);
      run_job(2'b10, 1000, 2000, 8'hEE, 3'd7, 1'b0, 0,
              g, dn, e, lat, starts, unstable, x_seen, on_seen, dn_after);
      check_eq("stmo_done", dn, 2'b10);
      check_eq("stmo_err", e, 1);
      check_eq("stmo_lat", lat, 11);
      check_eq("stmo_res", {res_y, res_s, res_b}, {8'h13, 3'd3, 1'b1});
      req = 2'b00;
      run_job(2'b01, 1, 3, 8'hA5, 3'd2, 1'b0, 0,
              g, dn, e, lat, starts, unstable, x_seen, on_seen, dn_after);
      check_eq("after_stmo_done", dn, 2'b01);
      check_eq("after_stmo_err", e, 0);
      check_eq("after_stmo_lat", lat, 5);
      check_eq("after_stmo_res", {res_y, res_s, res_b}, {8'hA5, 3'd2, 1'b0});

      // Run timeout on channel 1: active stuck high.
      req = 2'b00;
      x1 = 8'h77; mode1 = 2'b11;
      run_job(2'b10, 2, 2000, 8'h3C, 3'd1, 1'b1, 0,
              g, dn, e, lat, starts, unstable, x_seen, on_seen, dn_after);
      check_eq("rtmo_done", dn, 2'b10);
      check_eq("rtmo_err", e, 1);
      check_eq("rtmo_lat", lat, 69);
      check_eq("rtmo_cpon_run", on_seen, 2'b11);
      check_eq("rtmo_res", {res_y, res_s, res_b}, {8'hA5, 3'd2, 1'b0});
      req = 2'b00;
      check_eq("rtmo_cpon_after", {gnt, cp_on}, 4'b0000);

      // Mid-job disturbance: x0 and req0 change during RUN.
      x0 = 8'h33; mode0 = 2'b01;
      run_job(2'b01, 2, 7, 8'h5A, 3'd6, 1'b0, 5,
              g, dn, e, lat, starts, unstable, x_seen, on_seen, dn_after);
      check_eq("dist_dpx", x_seen, 8'h33);
      check_eq("dist_stable", unstable, 0);
      check_eq("dist_done", dn, 2'b01);
      check_eq("dist_once", dn_after, 2'b00);
      check_eq("dist_dpx_held", dp_x, 8'h33);

      // Reset mid-job, then both request: channel 0 must win.
      x0 = 8'h44; mode0 = 2'b01; req = 2'b01; cp_active = 1'b0;
      @(negedge clk);
      @(negedge clk);
      cp_active = 1'b1;
      @(negedge clk);
      check_eq("rst_pre_gnt", gnt, 2'b01);
      #2 rst_n = 1'b0;
      #1 check_eq("rst_async", {gnt, done, err, res_y, res_s, res_b, cp_on, cp_start, dp_x}, 0);
      @(negedge clk);
      check_eq("rst_no_done", done, 2'b00);
      rst_n = 1'b1; cp_active = 1'b0; req = 2'b11;
      @(negedge clk);
      check_eq("rst_first_gnt", gnt, 2'b01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
